pipe_hazard_unit: RTL and testbench
===================================

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter REG_W, default 5, register-index width.
REQ-002 Parameter NUM_SRC, default 3, number of ID-stage source operands checked (Rn, Rm, Rt).
REQ-003 Parameter LOAD_LAT, default 1, legal 1..7, load-use stall length in cycles.
REQ-004 Parameter ZERO_REG, default 31, index of XZR; it never creates a hazard.
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  pipeline clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 ex_mem_read  input  1  instruction in EX is a load.
REQ-009 ex_write_reg  input  REG_W  destination register of the EX instruction.
REQ-010 id_src_reg  input  NUM_SRC*REG_W  packed ID source indices; slot i at bits [i*REG_W +: REG_W].
REQ-011 id_src_valid  input  NUM_SRC  per-slot "operand actually read" flag.
REQ-012 ex_branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-013 pc_stall  output  1  hold PC (1 = do not update).
REQ-014 ifid_stall  output  1  hold IF/ID register.
REQ-015 idex_bubble  output  1  zero control signals into ID/EX.
REQ-016 ifid_flush  output  1  clear IF/ID to NOP.

Function
REQ-017 Slot i matches when id_src_valid[i]=1, id_src_reg slot i == ex_write_reg, and ex_write_reg != ZERO_REG; comparisons are 2-state equality; X/Z never matches.
REQ-018 hazard = ex_mem_read AND any slot matches.
REQ-019 FSM states: IDLE, LOAD_WAIT.
REQ-020 IDLE, hazard=1, ex_branch_taken=0: pc_stall=ifid_stall=idex_bubble=1 combinationally same cycle; if LOAD_LAT>1, go to LOAD_WAIT with cnt=LOAD_LAT-1, else stay IDLE.
REQ-021 LOAD_WAIT: pc_stall=ifid_stall=idex_bubble=1 regardless of inputs; cnt decrements each cycle; on the cycle cnt==1, return to IDLE; total stall = exactly LOAD_LAT consecutive cycles.
REQ-022 ex_branch_taken=1 in any state: ifid_flush=1, idex_bubble=1, pc_stall=0, ifid_stall=0; next state IDLE, cnt cleared; the flush overrides any pending or new stall.
REQ-023 No hazard, no branch, state IDLE: all outputs 0.
REQ-024 Back-to-back load-use hazards: after return to IDLE a new hazard starts a new LOAD_LAT stall with no idle gap required.
REQ-025 cnt width is 3 bits; it never wraps below 0.

Reset
REQ-026 reset=1 immediately forces state IDLE and cnt=0; outputs follow from REQ-023 and ignore hazard while reset=1.
REQ-027 Reset asserted mid-LOAD_WAIT aborts the stall; the first cycle after deassertion evaluates the inputs afresh.

Configuration
REQ-028 With HAZARD_STATS_EN defined, the block adds output stall_cycles (32 bits) counting cycles with pc_stall=1, and output flush_count (16 bits) counting ex_branch_taken cycles; both saturate at all-ones and clear on reset.
REQ-029 Without HAZARD_STATS_EN, neither port nor its counters exists; all other behaviour is identical.

Structure
REQ-030 Shared package hazard_pkg holds the FSM state enum, the ZERO_REG default, and the LOAD_LAT legal-range constants.
REQ-031 One sub-module, hazard_src_match, implements REQ-017 for one slot; it is instantiated NUM_SRC times via generate.
REQ-032 An illegal LOAD_LAT (0 or >7) is rejected at elaboration.

Verification
REQ-033 LOAD_LAT=1; ex_mem_read=1, ex_write_reg=16, slot0=16 valid -> stall signals 1 for exactly 1 cycle, then 0.
REQ-034 LOAD_LAT=3; ex_write_reg=12, slot1=12 valid -> pc_stall=ifid_stall=idex_bubble=1 for 3 consecutive cycles, then IDLE.
REQ-035 ex_write_reg=31 matching slot0, or a match on a slot with id_src_valid=0 -> no stall.
REQ-036 LOAD_LAT=3, ex_branch_taken=1 on the 2nd stall cycle -> that cycle ifid_flush=1, pc_stall=0; next cycle all outputs 0.
REQ-037 reset pulsed mid-LOAD_WAIT -> outputs drop asynchronously; with HAZARD_STATS_EN, stall_cycles reads 0.
REQ-038 ex_mem_read=0 with matching registers -> no stall; with HAZARD_STATS_EN, 5 stall cycles -> stall_cycles=5.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the load-use hazard unit: FSM encoding, XZR index
// and the legal load-latency range.
package hazard_pkg;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    localparam int ZERO_REG_DEFAULT = 31;
    localparam int LOAD_LAT_MIN     = 1;
    localparam int LOAD_LAT_MAX     = 7;
    localparam int CNT_W            = 3;

endpackage

// File: rtl/hazard_src_match.sv
// One ID source operand compared against the EX destination; XZR and
// operands the instruction does not read never match.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
    input  logic [REG_W-1:0] src_reg,
    input  logic             src_valid,
    input  logic [REG_W-1:0] write_reg,
    output logic             match
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    // An unknown compare result takes the else path, so X/Z never reports a match.
    always_comb begin
        // NOTE: assign a default before any condition so no path leaves match
        // unassigned; otherwise synthesis infers a latch.
        match = 1'b0;
        if (src_valid && (src_reg == write_reg) && (write_reg != ZERO_IDX))
            match = 1'b1;
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Load-use stall / branch flush control for the ID stage.
// Optional build macro HAZARD_STATS_EN adds saturating stall and flush counters.
module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int NUM_SRC  = 3,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ex_mem_read,
    input  logic [REG_W-1:0]         ex_write_reg,
    input  logic [NUM_SRC*REG_W-1:0] id_src_reg,
    input  logic [NUM_SRC-1:0]       id_src_valid,
    input  logic                     ex_branch_taken,
    output logic                     pc_stall,
    output logic                     ifid_stall,
    output logic                     idex_bubble,
    output logic                     ifid_flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]              stall_cycles,
    output logic [15:0]              flush_count
`endif
);

    generate
        if (LOAD_LAT < LOAD_LAT_MIN || LOAD_LAT > LOAD_LAT_MAX) begin : g_bad_lat
            $error("pipe_hazard_unit: LOAD_LAT must be in 1..7");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LOAD_LAT - 1);

    logic [NUM_SRC-1:0] src_match;
    logic               hazard;
    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_src_match #(
            .REG_W    (REG_W),
            .ZERO_REG (ZERO_REG)
        ) u_match (
            .src_reg   (id_src_reg[i*REG_W +: REG_W]),
            .src_valid (id_src_valid[i]),
            .write_reg (ex_write_reg),
            .match     (src_match[i])
        );
    end

    assign hazard = ex_mem_read & (|src_match);

    // Priority: reset silences everything, a taken branch beats any stall,
    // a running stall ignores fresh inputs, then a new hazard may start one.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        stall       = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (reset) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nxt   = IDLE;
            cnt_nxt     = '0;
        end else if (state == LOAD_WAIT) begin
            stall       = 1'b1;
            idex_bubble = 1'b1;
            if (cnt <= CNT_W'(1)) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end else if (hazard) begin
            stall       = 1'b1;
            idex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
                state_nxt = LOAD_WAIT;
                cnt_nxt   = CNT_START;
            end
        end
    end

    assign pc_stall   = stall;
    assign ifid_stall = stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (pc_stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (ex_branch_taken && (flush_count != '1))
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench: one LOAD_LAT=3 and one LOAD_LAT=1 instance share stimulus;
// outputs are checked as {pc_stall, ifid_stall, idex_bubble, ifid_flush}.
module tb_pipe_hazard_unit;

    logic        clk;
    logic        reset;
    logic        ex_mem_read;
    logic [4:0]  ex_write_reg;
    logic [14:0] id_src_reg;
    logic [2:0]  id_src_valid;
    logic        ex_branch_taken;

    logic pc3, is3, bb3, fl3;
    logic pc1, is1, bb1, fl1;
    logic [3:0] o3, o1;
`ifdef HAZARD_STATS_EN
    logic [31:0] sc3, sc1;
    logic [15:0] fc3, fc1;
`endif

    int vectors = 0;
    int miscompares = 0;

    localparam logic [3:0] S = 4'b1110;
    localparam logic [3:0] F = 4'b0011;
    localparam logic [3:0] Z = 4'b0000;

    pipe_hazard_unit #(.LOAD_LAT(3)) u_dut3 (
        .clk             (clk),
        .reset           (reset),
        .ex_mem_read     (ex_mem_read),
        .ex_write_reg    (ex_write_reg),
        .id_src_reg      (id_src_reg),
        .id_src_valid    (id_src_valid),
        .ex_branch_taken (ex_branch_taken),
        .pc_stall        (pc3),
        .ifid_stall      (is3),
        .idex_bubble     (bb3),
        .ifid_flush      (fl3)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles    (sc3),
        .flush_count     (fc3)
`endif
    );

    pipe_hazard_unit #(.LOAD_LAT(1)) u_dut1 (
        .clk             (clk),
        .reset           (reset),
        .ex_mem_read     (ex_mem_read),
        .ex_write_reg    (ex_write_reg),
        .id_src_reg      (id_src_reg),
        .id_src_valid    (id_src_valid),
        .ex_branch_taken (ex_branch_taken),
        .pc_stall        (pc1),
        .ifid_stall      (is1),
        .idex_bubble     (bb1),
        .ifid_flush      (fl1)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles    (sc1),
        .flush_count     (fc1)
`endif
    );

    assign o3 = {pc3, is3, bb3, fl3};
    assign o1 = {pc1, is1, bb1, fl1};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] wr, input logic [4:0] s0,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] v, input logic br);
        ex_mem_read     = mr;
        ex_write_reg    = wr;
        id_src_reg      = {s2, s1, s0};
        id_src_valid    = v;
        ex_branch_taken = br;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0);
    endtask

    // Checks combinational outputs mid-cycle, then advances just past the next edge.
    task automatic cycle(input string tag, input logic [3:0] e3, input logic [3:0] e1);
        @(negedge clk);
        check({tag, "/lat3"}, {28'd0, o3}, {28'd0, e3});
        check({tag, "/lat1"}, {28'd0, o1}, {28'd0, e1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk   = 1'b0;
        reset = 1'b0;
        drive(1'b1, 5'd16, 5'd16, 5'd0, 5'd0, 3'b001, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("rst_hold/lat3", {28'd0, o3}, 32'd0);
        check("rst_hold/lat1", {28'd0, o1}, 32'd0);
`ifdef HAZARD_STATS_EN
        check("rst_stats", sc3, 32'd0);
`endif
        @(posedge clk); #1;
        idle();
        reset = 1'b0;

        cycle("idle", Z, Z);

        drive(1'b1, 5'd16, 5'd16, 5'd0, 5'd0, 3'b001, 1'b0);
        cycle("lu_c1", S, S);
        idle();
        cycle("lu_c2", S, Z);
        cycle("lu_c3", S, Z);
        cycle("lu_end", Z, Z);

        drive(1'b1, 5'd31, 5'd31, 5'd0, 5'd0, 3'b001, 1'b0);
        cycle("xzr", Z, Z);
        drive(1'b1, 5'd7, 5'd0, 5'd0, 5'd7, 3'b011, 1'b0);
        cycle("invalid_slot", Z, Z);
        drive(1'b0, 5'd12, 5'd0, 5'd12, 5'd0, 3'b010, 1'b0);
        cycle("no_load", Z, Z);

        drive(1'b1, 5'd12, 5'd0, 5'd12, 5'd0, 3'b010, 1'b0);
        cycle("b2b_c1", S, S);
        idle();
        cycle("b2b_c2", S, Z);
        cycle("b2b_c3", S, Z);
        drive(1'b1, 5'd9, 5'd0, 5'd0, 5'd9, 3'b100, 1'b0);
        cycle("b2b_c4", S, S);
        idle();
        cycle("b2b_c5", S, Z);
        cycle("b2b_c6", S, Z);
        cycle("b2b_end", Z, Z);

        drive(1'b1, 5'd12, 5'd0, 5'd12, 5'd0, 3'b010, 1'b0);
        cycle("br_c1", S, S);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1);
        cycle("br_c2", F, F);
        idle();
        cycle("br_c3", Z, Z);
        drive(1'b1, 5'd5, 5'd5, 5'd0, 5'd0, 3'b001, 1'b1);
        cycle("br_hazard", F, F);
        idle();
        cycle("br_after", Z, Z);

        drive(1'b1, 5'd3, 5'd3, 5'd0, 5'd0, 3'b001, 1'b0);
        cycle("rm_c1", S, S);
        idle();
        @(negedge clk);
        check("rm_c2/lat3", {28'd0, o3}, {28'd0, S});
        #1 reset = 1'b1;
        #1;
        check("rm_async/lat3", {28'd0, o3}, 32'd0);
`ifdef HAZARD_STATS_EN
        check("rm_stats", sc3, 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b1, 5'd3, 5'd3, 5'd0, 5'd0, 3'b001, 1'b0);
        cycle("rm_fresh1", S, S);
        idle();
        cycle("rm_fresh2", S, Z);
        cycle("rm_fresh3", S, Z);
        cycle("rm_end", Z, Z);

        reset = 1'b1;
        #1 reset = 1'b0;
        drive(1'b1, 5'd20, 5'd0, 5'd20, 5'd0, 3'b010, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle($sformatf("hold_c%0d", i + 1), S, S);
        idle();
        cycle("hold_tail", S, Z);
        cycle("hold_end", Z, Z);
`ifdef HAZARD_STATS_EN
        check("stall_cycles/lat3", sc3, 32'd6);
        check("stall_cycles/lat1", sc1, 32'd5);
`endif
        drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1);
        cycle("flush_a", F, F);
        cycle("flush_b", F, F);
        idle();
        cycle("flush_end", Z, Z);
`ifdef HAZARD_STATS_EN
        check("flush_count/lat3", {16'd0, fc3}, 32'd2);
        check("flush_count/lat1", {16'd0, fc1}, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
